// File: rtl/data_mem_responder.sv
// data_mem_responder
// Memory-side responder for the multicycle CPU. It accepts one load/store at a
// time, drives the word-wide synchronous Memoria port, extracts and extends
// sub-word load data, and performs read-modify-write for byte/half stores.
module data_mem_responder #(
  parameter int MEM_LAT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  // The READ down-counter starts here so the last READ cycle sees count 0.
  localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

  state_t      state_q, state_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        req_err;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  // Illegal size or a half/word access that is not naturally aligned.
  assign req_err = (req_size == SIZE_ILL) ||
                   ((req_size == SIZE_HALF) && req_addr[0]) ||
                   ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));

  // Lane extraction/extension for loads and lane replacement for RMW stores.
  always_comb begin
    lane_byte  = mem_rdata[7:0];
    lane_half  = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data  = mem_rdata;
    merge_data = mem_rdata;
    case (addr_q[1:0])
      2'd0:    lane_byte = mem_rdata[7:0];
      2'd1:    lane_byte = mem_rdata[15:8];
      2'd2:    lane_byte = mem_rdata[23:16];
      default: lane_byte = mem_rdata[31:24];
    endcase
    case (size_q)
      SIZE_HALF: begin
        load_data = {{16{signed_q & lane_half[15]}}, lane_half};
        if (addr_q[1]) begin
          merge_data[31:16] = wdata_q[15:0];
        end else begin
          merge_data[15:0] = wdata_q[15:0];
        end
      end
      SIZE_BYTE: begin
        load_data = {{24{signed_q & lane_byte[7]}}, lane_byte};
        case (addr_q[1:0])
          2'd0:    merge_data[7:0]   = wdata_q[7:0];
          2'd1:    merge_data[15:8]  = wdata_q[7:0];
          2'd2:    merge_data[23:16] = wdata_q[7:0];
          default: merge_data[31:24] = wdata_q[7:0];
        endcase
      end
      default: begin
        load_data  = mem_rdata;
        merge_data = wdata_q;
      end
    endcase
  end

  // Next-state and datapath register updates for the request sequencer.
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    size_d      = size_q;
    signed_d    = signed_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d        = req_wr;
          size_d      = req_size;
          signed_d    = req_signed;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          cnt_d       = LAT_LAST;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
          if (req_err) begin
            state_d   = RESP;
            rsp_err_d = 1'b1;
          end else if (req_wr && (req_size == SIZE_WORD)) begin
            state_d     = WRITE;
            mem_wdata_d = req_wdata;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (cnt_q == 4'd0) begin
          if (wr_q) begin
            state_d     = WRITE;
            mem_wdata_d = merge_data;
          end else begin
            state_d     = RESP;
            rsp_rdata_d = load_data;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WRITE: begin
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      size_q      <= SIZE_WORD;
      signed_q    <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      cnt_q       <= 4'd0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = (state_q == RESP) ? rsp_rdata_q : 32'h0;
  assign rsp_err   = (state_q == RESP) ? rsp_err_q : 1'b0;
  assign mem_wr    = (state_q == WRITE);
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
// Drives three responders (MEM_LAT = 1, 2, 4) in lockstep from one request
// stream; each has its own Memoria model. Results are compared against
// hand-computed constants and a byte-array reference model.
module tb_data_mem_responder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        req_valid;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic [2:0]        req_ready_a;
  logic [2:0]        rsp_valid_a;
  logic [2:0]        rsp_err_a;
  logic [2:0]        mem_wr_a;
  logic [2:0][31:0]  rsp_rdata_a;
  logic [2:0][31:0]  mem_addr_a;
  logic [2:0][31:0]  mem_wdata_a;
  logic [2:0][31:0]  mem_rdata_a;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] ref_mem [0:255];

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 2 : 4);
  endfunction

  // One responder per latency, each with a word memory whose read data is
  // only valid once mem_addr has been held for MEM_LAT cycles after accept.
  for (genvar g = 0; g < 3; g++) begin : g_lane
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    logic [31:0] mem [0:63];
    int lat_cnt = 0;

    data_mem_responder #(.MEM_LAT(LAT)) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready_a[g]),
      .req_wr     (req_wr),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid_a[g]),
      .rsp_rdata  (rsp_rdata_a[g]),
      .rsp_err    (rsp_err_a[g]),
      .mem_addr   (mem_addr_a[g]),
      .mem_wr     (mem_wr_a[g]),
      .mem_wdata  (mem_wdata_a[g]),
      .mem_rdata  (mem_rdata_a[g])
    );

    // Memoria write port and read-latency tracker.
    always @(posedge clock) begin
      if (mem_wr_a[g]) begin
        mem[mem_addr_a[g][7:2]] <= mem_wdata_a[g];
      end
      if (req_valid && req_ready_a[g]) begin
        lat_cnt <= 0;
      end else if (lat_cnt < 1000) begin
        lat_cnt <= lat_cnt + 1;
      end
    end

    assign mem_rdata_a[g] = (lat_cnt >= LAT - 1 && !mem_wr_a[g]) ?
                            mem[mem_addr_a[g][7:2]] : 32'hBAD0_BAD0;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] a);
    return {ref_mem[{a[7:2], 2'd3}], ref_mem[{a[7:2], 2'd2}],
            ref_mem[{a[7:2], 2'd1}], ref_mem[{a[7:2], 2'd0}]};
  endfunction

  function automatic logic model_err(input logic [1:0] size, input logic [31:0] a);
    return (size == 2'b11) || (size == 2'b01 && a[0]) || (size == 2'b00 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] size, input logic sgn);
    logic [31:0] w;
    logic [15:0] h;
    logic [7:0]  b;
    w = model_word(a);
    h = {ref_mem[{a[7:1], 1'b1}], ref_mem[{a[7:1], 1'b0}]};
    b = ref_mem[a[7:0]];
    case (size)
      2'b00:   return w;
      2'b01:   return sgn ? {{16{h[15]}}, h} : {16'h0, h};
      2'b10:   return sgn ? {{24{b[7]}}, b} : {24'h0, b};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_merge(input logic [31:0] a, input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] w;
    w = model_word(a);
    case (size)
      2'b00:   w = wd;
      2'b01:   w[16*int'(a[1]) +: 16] = wd[15:0];
      2'b10:   w[8*int'(a[1:0]) +: 8] = wd[7:0];
      default: w = w;
    endcase
    return w;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] w;
    w = model_merge(a, size, wd);
    for (int k = 0; k < 4; k++) begin
      ref_mem[{a[7:2], 2'(k)}] = w[8*k +: 8];
    end
  endtask

  // Issues one request to all three responders and checks response timing,
  // data, error flag, write pulse and ready handshake for each of them.
  task automatic applyStimulus(input string tag, input logic wr, input logic [1:0] size,
                               input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic exp_err, input logic [31:0] exp_rdata,
                               input logic [31:0] exp_wdata);
    int          wr_cnt [3];
    int          wr_cyc [3];
    int          rsp_cnt [3];
    int          rsp_cyc [3];
    int          addr_bad [3];
    int          exp_rsp [3];
    int          exp_wr_cyc [3];
    logic        ready1 [3];
    logic        ready_after [3];
    logic        err_seen [3];
    logic [31:0] wdata_seen [3];
    logic [31:0] rdata_seen [3];
    int          exp_wr_cnt;
    logic [31:0] exp_rsp_data;
    int          lat;

    exp_wr_cnt   = (wr && !exp_err) ? 1 : 0;
    exp_rsp_data = (!wr && !exp_err) ? exp_rdata : 32'h0;
    for (int g = 0; g < 3; g++) begin
      lat = lat_of(g);
      wr_cnt[g] = 0; wr_cyc[g] = 0; rsp_cnt[g] = 0; rsp_cyc[g] = 0; addr_bad[g] = 0;
      ready1[g] = 1'b1; ready_after[g] = 1'b0; err_seen[g] = 1'b0;
      wdata_seen[g] = 32'h0; rdata_seen[g] = 32'h0;
      if (exp_err) begin
        exp_rsp[g] = 1; exp_wr_cyc[g] = 0;
      end else if (wr && size == 2'b00) begin
        exp_rsp[g] = 2; exp_wr_cyc[g] = 1;
      end else if (wr) begin
        exp_rsp[g] = 2 + lat; exp_wr_cyc[g] = 1 + lat;
      end else begin
        exp_rsp[g] = 1 + lat; exp_wr_cyc[g] = 0;
      end
    end

    @(negedge clock);
    req_wr = wr; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    for (int g = 0; g < 3; g++) begin
      checkOutput($sformatf("%s L%0d ready_idle", tag, lat_of(g)), 32'(req_ready_a[g]), 32'd1);
    end
    @(posedge clock);

    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if (c == 2) req_valid = 1'b0;
      for (int g = 0; g < 3; g++) begin
        if (c == 1) ready1[g] = req_ready_a[g];
        if (rsp_cnt[g] != 0 && c == rsp_cyc[g] + 1) ready_after[g] = req_ready_a[g];
        if (!exp_err && c < exp_rsp[g] && mem_addr_a[g] !== {addr[31:2], 2'b00}) addr_bad[g]++;
        if (mem_wr_a[g]) begin
          wr_cnt[g]++; wr_cyc[g] = c; wdata_seen[g] = mem_wdata_a[g];
        end
        if (rsp_valid_a[g]) begin
          rsp_cnt[g]++; rsp_cyc[g] = c; rdata_seen[g] = rsp_rdata_a[g]; err_seen[g] = rsp_err_a[g];
        end
      end
    end

    for (int g = 0; g < 3; g++) begin
      lat = lat_of(g);
      checkOutput($sformatf("%s L%0d rsp_count", tag, lat), 32'(rsp_cnt[g]), 32'd1);
      checkOutput($sformatf("%s L%0d rsp_cycle", tag, lat), 32'(rsp_cyc[g]), 32'(exp_rsp[g]));
      checkOutput($sformatf("%s L%0d rsp_err", tag, lat), 32'(err_seen[g]), 32'(exp_err));
      checkOutput($sformatf("%s L%0d rsp_rdata", tag, lat), rdata_seen[g], exp_rsp_data);
      checkOutput($sformatf("%s L%0d wr_count", tag, lat), 32'(wr_cnt[g]), 32'(exp_wr_cnt));
      checkOutput($sformatf("%s L%0d busy_ready", tag, lat), 32'(ready1[g]), 32'd0);
      checkOutput($sformatf("%s L%0d ready_after", tag, lat), 32'(ready_after[g]), 32'd1);
      if (exp_wr_cnt != 0) begin
        checkOutput($sformatf("%s L%0d wr_cycle", tag, lat), 32'(wr_cyc[g]), 32'(exp_wr_cyc[g]));
        checkOutput($sformatf("%s L%0d mem_wdata", tag, lat), wdata_seen[g], exp_wdata);
      end
      if (!exp_err) begin
        checkOutput($sformatf("%s L%0d addr_unstable", tag, lat), 32'(addr_bad[g]), 32'd0);
      end
    end

    if (wr && !exp_err) model_store(addr, size, wdata);
  endtask

  // Starts a byte store, resets during its READ phase and checks that the
  // access is silently dropped.
  task automatic applyResetAbort();
    int wr_cnt [3];
    int rsp_cnt [3];
    for (int g = 0; g < 3; g++) begin
      wr_cnt[g] = 0; rsp_cnt[g] = 0;
    end
    @(negedge clock);
    req_wr = 1'b1; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h21; req_wdata = 32'h55;
    req_valid = 1'b1;
    @(posedge clock);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      for (int g = 0; g < 3; g++) begin
        if (mem_wr_a[g]) wr_cnt[g]++;
        if (rsp_valid_a[g]) rsp_cnt[g]++;
        if (c == 2) begin
          checkOutput($sformatf("abort L%0d ready", lat_of(g)), 32'(req_ready_a[g]), 32'd1);
          checkOutput($sformatf("abort L%0d mem_addr", lat_of(g)), mem_addr_a[g], 32'h0);
        end
      end
      if (c == 1) begin
        req_valid = 1'b0;
        reset = 1'b1;
      end
      if (c == 2) reset = 1'b0;
    end
    for (int g = 0; g < 3; g++) begin
      checkOutput($sformatf("abort L%0d wr_count", lat_of(g)), 32'(wr_cnt[g]), 32'd0);
      checkOutput($sformatf("abort L%0d rsp_count", lat_of(g)), 32'(rsp_cnt[g]), 32'd0);
    end
  endtask

  initial begin
    logic        r_wr;
    logic        r_sgn;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] pat;

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    for (int g = 0; g < 3; g++) begin
      checkOutput($sformatf("reset L%0d req_ready", lat_of(g)), 32'(req_ready_a[g]), 32'd1);
      checkOutput($sformatf("reset L%0d rsp_valid", lat_of(g)), 32'(rsp_valid_a[g]), 32'd0);
      checkOutput($sformatf("reset L%0d rsp_rdata", lat_of(g)), rsp_rdata_a[g], 32'h0);
      checkOutput($sformatf("reset L%0d rsp_err", lat_of(g)), 32'(rsp_err_a[g]), 32'd0);
      checkOutput($sformatf("reset L%0d mem_wr", lat_of(g)), 32'(mem_wr_a[g]), 32'd0);
      checkOutput($sformatf("reset L%0d mem_addr", lat_of(g)), mem_addr_a[g], 32'h0);
      checkOutput($sformatf("reset L%0d mem_wdata", lat_of(g)), mem_wdata_a[g], 32'h0);
    end
    reset = 1'b0;

    applyStimulus("st_w10", 1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 32'hDEADBEEF);
    applyStimulus("ld_w10", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 32'h0);

    applyStimulus("st_w20", 1'b1, 2'b00, 1'b0, 32'h20, 32'h11223344, 1'b0, 32'h0, 32'h11223344);
    applyStimulus("st_b22", 1'b1, 2'b10, 1'b0, 32'h22, 32'hFFFFFFAA, 1'b0, 32'h0, 32'h11AA3344);
    applyStimulus("ld_w20", 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 1'b0, 32'h11AA3344, 32'h0);
    applyStimulus("st_h22", 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF, 1'b0, 32'h0, 32'hBEEF3344);

    applyStimulus("st_w30", 1'b1, 2'b00, 1'b0, 32'h30, 32'h80FF7F01, 1'b0, 32'h0, 32'h80FF7F01);
    applyStimulus("ld_b32s", 1'b0, 2'b10, 1'b1, 32'h32, 32'h0, 1'b0, 32'hFFFFFFFF, 32'h0);
    applyStimulus("ld_b31u", 1'b0, 2'b10, 1'b0, 32'h31, 32'h0, 1'b0, 32'h0000007F, 32'h0);
    applyStimulus("ld_h32s", 1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 1'b0, 32'hFFFF80FF, 32'h0);
    applyStimulus("ld_h32u", 1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 1'b0, 32'h000080FF, 32'h0);
    applyStimulus("ld_b33s", 1'b0, 2'b10, 1'b1, 32'h33, 32'h0, 1'b0, 32'hFFFFFF80, 32'h0);

    applyStimulus("err_h31", 1'b0, 2'b01, 1'b1, 32'h31, 32'h0, 1'b1, 32'h0, 32'h0);
    applyStimulus("err_w12", 1'b1, 2'b00, 1'b0, 32'h12, 32'h12345678, 1'b1, 32'h0, 32'h0);
    applyStimulus("err_sz3", 1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 1'b1, 32'h0, 32'h0);

    applyResetAbort();
    applyStimulus("ld_w20_abort", 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 1'b0, 32'hBEEF3344, 32'h0);

    for (int w = 0; w < 16; w++) begin
      pat = 32'h9E37_79B9 * 32'(w + 1);
      applyStimulus($sformatf("pre%0d", w), 1'b1, 2'b00, 1'b0, 32'(w * 4), pat, 1'b0, 32'h0, pat);
    end

    for (int i = 0; i < 40; i++) begin
      r_wr    = 1'($urandom_range(0, 1));
      r_size  = 2'($urandom_range(0, 3));
      r_sgn   = 1'($urandom_range(0, 1));
      r_addr  = 32'($urandom_range(0, 63));
      r_wdata = $urandom();
      applyStimulus($sformatf("rnd%0d", i), r_wr, r_size, r_sgn, r_addr, r_wdata,
                    model_err(r_size, r_addr), model_load(r_addr, r_size, r_sgn),
                    model_merge(r_addr, r_size, r_wdata));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
